mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the 128-word data Memory.
- Takes byte-addressed CPU requests: RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW.
- Converts each request into word-indexed Memory accesses and performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data through a single-cycle response pulse.

Parameters:
- DEPTH, 128, number of 32-bit words in the attached Memory.
- AW, 7, word-index width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_op  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or illegal op.
- m_addr  output  32  word index to Memory: zero-extended req_addr[AW+1:2].
- m_w_data  output  32  write word to Memory.
- mem_write  output  1  Memory write enable; Memory writes on negedge while this is high.
- m_r_data  input  32  Memory read data, registered one cycle after m_addr.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_write=0, m_addr=0, m_w_data=0.
- Reset is asynchronous: mem_write falls immediately, even mid-WRITE.
- FSM states: IDLE, READ, CAPT, WRITE, RESP.
- req_ready = (state==IDLE).
- mem_write = (state==WRITE), decoded from registered state only, so it is glitch-free and stable at the negedge.
- IDLE: on req_valid, latch addr, op, we and wdata.
  - Error → RESP with err=1 and no Memory activity.
  - SW → WRITE.
  - Any other legal op → READ.
- Error conditions:
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
  - Out of range: addr[31:AW+2]≠0.
  - Illegal op: 011, 110, 111 for loads; anything other than 000/001/010 for stores.
- READ: drive m_addr. Memory captures on the closing posedge. Next state CAPT.
- CAPT: m_r_data is valid.
  - Load: register the extracted, extended lane into resp_rdata; → RESP.
  - SB/SH: merge the store lane into m_r_data and register it in m_w_data; → WRITE.
- WRITE: m_addr held, m_w_data held, mem_write=1 for exactly one cycle. Next state RESP.
- RESP: resp_valid=1 for one cycle, then → IDLE. Requests are not accepted in RESP.
- Lane rules (little-endian):
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - SB writes wdata[7:0]; SH writes wdata[15:0]; untouched bytes keep their read value.
- Latency from the accept cycle T: SW resp at T+2; loads at T+3; SB/SH at T+4; errors at T+1.
- m_addr and m_w_data hold their values outside active states. Memory must ignore them when mem_write=0.
- Latched request fields are immune to req_* changes after accept.

Decomposition:
- Package mem_access_pkg holds:
  - funct3 constants (OP_B, OP_H, OP_W, OP_BU, OP_HU).
  - FSM state enum.
  - DEPTH and AW defaults.
- One combinational sub-module, mem_lane_unit:
  - Inputs: word, addr[1:0], op, store data.
  - Outputs: extended load value, merged store word, misalign flag.
  - Shared by the CAPT and IDLE decode paths.

Test Plan:
- Store word: after reset, SW addr 0x10, data 0xDEADBEEF.
  - Exactly one mem_write cycle at T+1 with m_addr=4, m_w_data=0xDEADBEEF.
  - resp_valid at T+2 with err=0.
- Byte loads from that word:
  - LB 0x13 → resp_rdata 0xFFFFFFDE at T+3.
  - LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x10 → 0x0000BEEF.
- Sub-word stores:
  - SB 0x11, data 0x55 → READ, CAPT, then mem_write at T+3 with m_w_data 0xDEAD55EF; resp at T+4.
  - Following LW 0x10 returns 0xDEAD55EF.
  - SH 0x12, data 0x1234 → word becomes 0x123455EF.
- Errors:
  - LH 0x11, SW 0x0E, LW 0x200 and load op 011 each give resp_err=1, rdata=0 at T+1.
  - No READ/WRITE cycle occurs and mem_write stays 0 throughout.
- Reset mid-operation:
  - rst asserted during CAPT of SB: mem_write never rises, req_ready=1 immediately.
  - rst asserted mid-WRITE: mem_write drops asynchronously before the next edge.
- Back-to-back requests with req_valid held high:
  - Second request is accepted only in the IDLE cycle after RESP.
  - resp_valid pulses exactly once per request.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared funct3 encodings, FSM state type and geometry defaults for the
// load/store front-end.
package mem_access_pkg;

    localparam int unsigned DEF_DEPTH = 128;
    localparam int unsigned DEF_AW    = 7;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        WRITE,
        RESP
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response channel of the load/store unit.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_access_unit_lane.sv
// Little-endian lane extraction/extension for loads, lane merge for
// sub-word stores, and alignment check.
module mem_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  op,
    input  logic [31:0] sdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word,
    output logic        misalign
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    always_comb begin
        byte_sh  = word >> {lane, 3'b000};
        half_sh  = word >> {lane[1], 4'b0000};
        load_val = '0;
        case (op)
            OP_B:    load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
            OP_BU:   load_val = {24'h0, byte_sh[7:0]};
            OP_H:    load_val = {{16{half_sh[15]}}, half_sh[15:0]};
            OP_HU:   load_val = {16'h0, half_sh[15:0]};
            OP_W:    load_val = word;
            default: load_val = '0;
        endcase
    end

    always_comb begin
        store_word = word;
        case (op)
            OP_B:    store_word[{lane, 3'b000} +: 8]     = sdata[7:0];
            OP_H:    store_word[{lane[1], 4'b0000} +: 16] = sdata[15:0];
            OP_W:    store_word = sdata;
            default: store_word = word;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        case (op)
            OP_H, OP_HU: misalign = lane[0];
            OP_W:        misalign = |lane;
            default:     misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed RISC-V load/store front-end for a word-indexed memory with
// registered reads; sub-word stores are done as read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus,
    output logic [31:0]        m_addr,
    output logic [31:0]        m_w_data,
    output logic               mem_write,
    input  logic [31:0]        m_r_data
);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  lane_q;
    logic [2:0]  op_q;
    logic        we_q;
    logic [31:0] wdata_q;

    logic [1:0]  lane_sel;
    logic [2:0]  op_sel;
    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        misalign;
    logic        illegal;
    logic        out_of_range;
    logic        req_err;
    logic        accept;

    // The lane unit serves both the IDLE error decode (live request) and
    // the CAPT extract/merge (latched request).
    assign lane_sel = (state == IDLE) ? bus.req_addr[1:0] : lane_q;
    assign op_sel   = (state == IDLE) ? bus.req_op : op_q;

    mem_lane_unit u_lane (
        .word       (m_r_data),
        .lane       (lane_sel),
        .op         (op_sel),
        .sdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word),
        .misalign   (misalign)
    );

    always_comb begin
        illegal = 1'b1;
        case (bus.req_op)
            OP_B, OP_H, OP_W: illegal = 1'b0;
            OP_BU, OP_HU:     illegal = bus.req_we;
            default:          illegal = 1'b1;
        endcase
    end

    assign out_of_range = (bus.req_addr[31:2] >= 30'(DEPTH));
    assign req_err      = misalign | illegal | out_of_range;
    assign accept       = bus.req_valid && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)                              state_nx = RESP;
                    else if (bus.req_we && bus.req_op == OP_W) state_nx = WRITE;
                    else                                      state_nx = READ;
                end
            end
            READ:    state_nx = CAPT;
            CAPT:    state_nx = we_q ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        mem_write      = (state == WRITE);
        bus.resp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q         <= '0;
            op_q           <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            m_addr         <= '0;
            m_w_data       <= '0;
        end else if (accept) begin
            lane_q         <= bus.req_addr[1:0];
            op_q           <= bus.req_op;
            we_q           <= bus.req_we;
            wdata_q        <= bus.req_wdata;
            bus.resp_err   <= req_err;
            bus.resp_rdata <= '0;
            // Errors leave the memory-side address/data untouched.
            if (!req_err) begin
                m_addr <= {{(32 - AW){1'b0}}, bus.req_addr[AW+1:2]};
                if (bus.req_we && bus.req_op == OP_W) m_w_data <= bus.req_wdata;
            end
        end else if (state == CAPT) begin
            if (we_q) m_w_data       <= store_word;
            else      bus.resp_rdata <= load_val;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses/writes; negedge monitors pop and compare.
module tb_mem_access_unit;

    typedef struct {
        int unsigned cyc;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] m_addr;
    logic [31:0] m_w_data;
    logic        mem_write;
    logic [31:0] m_r_data;

    logic [31:0] mem [128];
    int unsigned cyc;
    int unsigned checks;
    int unsigned failures;
    exp_t        resp_q[$];
    exp_t        wr_q[$];

    mem_access_unit_if bus ();

    mem_access_unit #(.DEPTH(128), .AW(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .m_addr    (m_addr),
        .m_w_data  (m_w_data),
        .mem_write (mem_write),
        .m_r_data  (m_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        m_r_data = '0;
    end
    always @(negedge clk) if (mem_write) mem[m_addr[6:0]] <= m_w_data;
    always @(posedge clk) m_r_data <= mem[m_addr[6:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = resp_q.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_rdata", bus.resp_rdata, e.d);
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.e});
                end
            end
            if (mem_write) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    chk("write_cycle", cyc, e.cyc);
                    chk("write_addr", m_addr, e.a);
                    chk("write_data", m_w_data, e.d);
                end
            end
        end
    end

    task automatic send(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output int unsigned t);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("req_ready_wait", 32'd0, 32'd1);
        bus.req_we    = we;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_op    = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_e,
                          input int unsigned lat, input int unsigned wr_lat, input logic [31:0] wr_d);
        int unsigned t;
        send(we, op, addr, wdata, t);
        resp_q.push_back('{cyc: t + lat, a: 32'd0, d: exp_d, e: exp_e});
        if (wr_lat != 0) wr_q.push_back('{cyc: t + wr_lat, a: {25'd0, addr[8:2]}, d: wr_d, e: 1'b0});
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("resp_q_empty", resp_q.size(), 32'd0);
        chk("wr_q_empty", wr_q.size(), 32'd0);
    endtask

    initial begin
        int unsigned t;
        int unsigned c0;
        int unsigned n;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #12;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_w_data", m_w_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stores and loads: we, op, addr, wdata, rdata, err, resp latency, write latency, write data
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF);
        do_req(1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 3, 0, 32'h0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0, 3, 0, 32'h0);
        do_req(1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 3, 0, 32'h0);
        do_req(1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 3, 0, 32'h0);
        do_req(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 32'h0,        1'b0, 4, 3, 32'hDEAD55EF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 3, 0, 32'h0);
        do_req(1'b1, 3'b001, 32'h12, 32'hABCD1234, 32'h0,        1'b0, 4, 3, 32'h123455EF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0, 3, 0, 32'h0);

        // Errors: misaligned LH, misaligned SW, out-of-range LW, illegal load op, illegal store op
        do_req(1'b0, 3'b001, 32'h11,  32'h0,        32'h0, 1'b1, 1, 0, 32'h0);
        do_req(1'b1, 3'b010, 32'h0E,  32'h11111111, 32'h0, 1'b1, 1, 0, 32'h0);
        do_req(1'b0, 3'b010, 32'h200, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0);
        do_req(1'b0, 3'b011, 32'h10,  32'h0,        32'h0, 1'b1, 1, 0, 32'h0);
        do_req(1'b1, 3'b100, 32'h10,  32'h22222222, 32'h0, 1'b1, 1, 0, 32'h0);
        drain();

        // Reset during CAPT of an SB: no write, no response
        send(1'b1, 3'b000, 32'h10, 32'h000000AA, t);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("capt_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("capt_rst_mem_write", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, 3, 0, 32'h0);

        // Reset in the middle of WRITE: mem_write drops before the negedge
        send(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, t);
        chk("write_state_mem_write", {31'd0, mem_write}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("write_rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("write_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 3, 0, 32'h0);
        drain();

        // Back-to-back with req_valid held high
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.req_we    = 1'b0;
        bus.req_op    = 3'b010;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0;
        bus.req_valid = 1'b1;
        c0 = cyc;
        resp_q.push_back('{cyc: c0 + 3, a: 32'd0, d: 32'h123455EF, e: 1'b0});
        resp_q.push_back('{cyc: c0 + 7, a: 32'd0, d: 32'h123455EF, e: 1'b0});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) chk("b2b_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
            if (k == 4) chk("b2b_ready_after_resp", {31'd0, bus.req_ready}, 32'd1);
        end
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
